// File: rtl/pka_pkg.sv
// Shared types and constants for the PKA command sequencer.
package pka_pkg;

  localparam int PKA_WORD_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_N = 3'd1,
    ST_LOAD_D = 3'd2,
    ST_LOAD_M = 3'd3,
    ST_KICK   = 3'd4,
    ST_WAIT   = 3'd5,
    ST_UNLOAD = 3'd6,
    ST_ERR    = 3'd7
  } pka_seq_state_t;

  typedef enum logic [1:0] {
    PKA_ERR_NONE    = 2'd0,
    PKA_ERR_TIMEOUT = 2'd1,
    PKA_ERR_ENGINE  = 2'd2
  } pka_err_e;

  // True in the three operand streaming states.
  function automatic logic is_load_state(input pka_seq_state_t s);
    return (s == ST_LOAD_N) || (s == ST_LOAD_D) || (s == ST_LOAD_M);
  endfunction

endpackage

// File: rtl/pka_result_serializer.sv
// Captures the wide engine result and streams it out as 32-bit words, word 0
// first, over a valid/ready port with out_last marking the final word.
//
// Handshake: a word transfers on a cycle where out_valid and out_ready are both
// high; out_valid and out_data are registered and stay stable until that happens.
module pka_result_serializer
  import pka_pkg::*;
#(
  parameter int KEY_SIZE = 2048
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  capture,
  input  logic                  clear,
  input  logic [KEY_SIZE-1:0]   result,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [PKA_WORD_W-1:0] out_data,
  output logic                  out_last
);

  localparam int NW = KEY_SIZE / PKA_WORD_W;
  localparam int KW = (NW > 1) ? $clog2(NW) : 1;

  // Remaining (not yet presented) words; shifted down one word per handshake.
  logic [KEY_SIZE-1:0] res_q;
  logic [KW-1:0]       k_q;
  logic                hs;

  assign hs = out_valid & out_ready;

  // Capture on engine completion, then present one word per accepted handshake.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      res_q     <= '0;
      k_q       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (clear) begin
      k_q       <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (capture) begin
      res_q     <= result >> PKA_WORD_W;
      out_data  <= result[PKA_WORD_W-1:0];
      out_valid <= 1'b1;
      out_last  <= (NW == 1);
      k_q       <= '0;
    end else if (hs) begin
      if (out_last) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        k_q       <= '0;
      end else begin
        out_data <= res_q[PKA_WORD_W-1:0];
        res_q    <= res_q >> PKA_WORD_W;
        k_q      <= k_q + KW'(1);
        out_last <= (k_q == KW'(NW - 2));
      end
    end
  end

endmodule

// File: rtl/pka_cmd_sequencer.sv
// Host-side initiator for the RSA/ECC engine: takes a command, streams N, D and
// M in as 32-bit words, kicks the engine, waits with a timeout and streams the
// wide result back out.
//
// Handshakes: cmd, in and out ports all use valid/ready; a transfer happens on
// a cycle where both are high. Ready signals depend only on state, never on valid.
// KEY_SIZE must be a multiple of 32 giving at least two words.
module pka_cmd_sequencer
  import pka_pkg::*;
#(
  parameter int KEY_SIZE    = 2048,
  parameter int TIMEOUT_CYC = 4194304
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_is_rsa,
  input  logic                  abort,
  input  logic                  err_clr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PKA_WORD_W-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PKA_WORD_W-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  err,
  output logic [1:0]            err_code,
  output logic                  eng_start,
  output logic                  eng_is_rsa,
  output logic [KEY_SIZE-1:0]   eng_n,
  output logic [KEY_SIZE-1:0]   eng_d,
  output logic [KEY_SIZE-1:0]   eng_m,
  input  logic                  eng_done,
  input  logic                  eng_error,
  input  logic [KEY_SIZE-1:0]   eng_result,
  output pka_seq_state_t        dbg_state
);

  localparam int NW = KEY_SIZE / PKA_WORD_W;
  localparam int KW = (NW > 1) ? $clog2(NW) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  pka_seq_state_t      state_q, state_d;
  pka_err_e            err_code_q, code_d;
  logic [KW-1:0]       k_q;
  logic [TW-1:0]       tmo_q;
  logic                is_rsa_q;
  logic [KEY_SIZE-1:0] n_q, d_q, m_q;
  logic                in_hs, last_word, capture, unload_done;

  assign in_hs       = in_valid & in_ready;
  assign last_word   = (k_q == KW'(NW - 1));
  assign unload_done = out_valid & out_ready & out_last;

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state, error code and result-capture decode; abort overrides everything.
  always_comb begin
    state_d = state_q;
    code_d  = err_code_q;
    capture = 1'b0;
    case (state_q)
      ST_IDLE:   if (cmd_valid) state_d = ST_LOAD_N;
      ST_LOAD_N: if (in_hs && last_word) state_d = ST_LOAD_D;
      ST_LOAD_D: if (in_hs && last_word) state_d = ST_LOAD_M;
      ST_LOAD_M: if (in_hs && last_word) state_d = ST_KICK;
      ST_KICK:   state_d = ST_WAIT;
      ST_WAIT: begin
        // Engine error beats done, done beats timeout.
        if (eng_error) begin
          state_d = ST_ERR;
          code_d  = PKA_ERR_ENGINE;
        end else if (eng_done) begin
          state_d = ST_UNLOAD;
          capture = 1'b1;
        end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
          state_d = ST_ERR;
          code_d  = PKA_ERR_TIMEOUT;
        end
      end
      ST_UNLOAD: if (unload_done) state_d = ST_IDLE;
      ST_ERR: begin
        if (err_clr) begin
          state_d = ST_IDLE;
          code_d  = PKA_ERR_NONE;
        end
      end
      default:   state_d = ST_IDLE;
    endcase
    if (abort) begin
      state_d = ST_IDLE;
      code_d  = PKA_ERR_NONE;
      capture = 1'b0;
    end
  end

  // Word counter, timeout counter, command latch and error code.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      k_q        <= '0;
      tmo_q      <= '0;
      is_rsa_q   <= 1'b0;
      err_code_q <= PKA_ERR_NONE;
    end else begin
      err_code_q <= code_d;
      if (abort) begin
        k_q   <= '0;
        tmo_q <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (cmd_valid) begin
              is_rsa_q <= cmd_is_rsa;
              k_q      <= '0;
            end
          end
          ST_LOAD_N, ST_LOAD_D, ST_LOAD_M: begin
            if (in_hs) k_q <= last_word ? '0 : k_q + KW'(1);
          end
          ST_KICK: tmo_q <= '0;
          ST_WAIT: tmo_q <= tmo_q + TW'(1);
          default: ;
        endcase
      end
    end
  end

  // Operand packing: word k of the current stream lands in bits [k*32 +: 32].
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      n_q <= '0;
      d_q <= '0;
      m_q <= '0;
    end else if (in_hs && !abort) begin
      for (int w = 0; w < NW; w++) begin
        if (k_q == KW'(w)) begin
          case (state_q)
            ST_LOAD_N: n_q[w*PKA_WORD_W +: PKA_WORD_W] <= in_data;
            ST_LOAD_D: d_q[w*PKA_WORD_W +: PKA_WORD_W] <= in_data;
            ST_LOAD_M: m_q[w*PKA_WORD_W +: PKA_WORD_W] <= in_data;
            default: ;
          endcase
        end
      end
    end
  end

  pka_result_serializer #(
    .KEY_SIZE (KEY_SIZE)
  ) u_ser (
    .clk       (clk),
    .rstn      (rstn),
    .capture   (capture),
    .clear     (abort),
    .result    (eng_result),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  assign cmd_ready  = (state_q == ST_IDLE);
  assign in_ready   = is_load_state(state_q);
  assign busy       = (state_q != ST_IDLE);
  assign err        = (state_q == ST_ERR);
  assign err_code   = err_code_q;
  // Gated by abort so a KICK cycle that is aborted never starts the engine.
  assign eng_start  = (state_q == ST_KICK) && !abort;
  assign eng_is_rsa = is_rsa_q;
  assign eng_n      = n_q;
  assign eng_d      = d_q;
  assign eng_m      = m_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_pka_cmd_sequencer.sv
// Directed plus randomized bench for pka_cmd_sequencer with a stub engine.
module tb_pka_cmd_sequencer;
  import pka_pkg::*;

  localparam int KEY_SIZE    = 64;
  localparam int NW          = KEY_SIZE / 32;
  localparam int TIMEOUT_CYC = 16;

  logic                clk, rstn;
  logic                cmd_valid, cmd_ready, cmd_is_rsa, abort, err_clr;
  logic                in_valid, in_ready;
  logic [31:0]         in_data;
  logic                out_valid, out_ready, out_last;
  logic [31:0]         out_data;
  logic                busy, err, eng_start, eng_is_rsa, eng_done, eng_error;
  logic [1:0]          err_code;
  logic [KEY_SIZE-1:0] eng_n, eng_d, eng_m, eng_result;
  pka_seq_state_t      dbg_state;

  pka_cmd_sequencer #(
    .KEY_SIZE    (KEY_SIZE),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_is_rsa (cmd_is_rsa),
    .abort      (abort),
    .err_clr    (err_clr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy),
    .err        (err),
    .err_code   (err_code),
    .eng_start  (eng_start),
    .eng_is_rsa (eng_is_rsa),
    .eng_n      (eng_n),
    .eng_d      (eng_d),
    .eng_m      (eng_m),
    .eng_done   (eng_done),
    .eng_error  (eng_error),
    .eng_result (eng_result),
    .dbg_state  (dbg_state)
  );

  // Clock / reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard state and reference model of the operand registers.
  int          checks = 0;
  int          failures = 0;
  int          start_cnt = 0;
  logic [31:0] exp_q[$];
  logic [63:0] mdl_n, mdl_d, mdl_m;
  logic        mdl_rsa;

  // Count every engine start pulse seen mid-cycle.
  always @(negedge clk) if (rstn && eng_start) start_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_cmd(input logic rsa);
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid  = 1'b1;
    cmd_is_rsa = rsa;
    in_valid   = 1'b1;            // must be ignored while idle
    in_data    = 32'hBAD0BAD0;
    tick();
    cmd_valid = 1'b0;
    in_valid  = 1'b0;
    mdl_rsa   = rsa;
    chk("busy_after_cmd", busy, 1);
    chk("eng_is_rsa_latched", eng_is_rsa, rsa);
  endtask

  // Stream the first n words of val into operand op (0=N, 1=D, 2=M).
  task automatic load_op(input int op, input logic [63:0] val, input int n);
    for (int i = 0; i < n; i++) begin
      int gap = $urandom_range(0, 1);
      for (int g = 0; g < gap; g++) tick();
      in_valid = 1'b1;
      in_data  = val[i*32 +: 32];
      chk("in_ready_load", in_ready, 1);
      tick();
      in_valid = 1'b0;
      case (op)
        0: mdl_n[i*32 +: 32] = val[i*32 +: 32];
        1: mdl_d[i*32 +: 32] = val[i*32 +: 32];
        default: mdl_m[i*32 +: 32] = val[i*32 +: 32];
      endcase
    end
  endtask

  // Called right after the last M word: expect the single start pulse now.
  task automatic kick_check();
    int sc = start_cnt;
    chk("eng_start_kick", eng_start, 1);
    chk("eng_n", eng_n, mdl_n);
    chk("eng_d", eng_d, mdl_d);
    chk("eng_m", eng_m, mdl_m);
    chk("eng_is_rsa_kick", eng_is_rsa, mdl_rsa);
    chk("in_ready_kick", in_ready, 0);
    tick();
    chk("eng_start_single", eng_start, 0);
    chk("start_cnt_plus1", start_cnt, sc + 1);
  endtask

  task automatic full_load(input logic rsa, input logic [63:0] n, input logic [63:0] d,
                           input logic [63:0] m);
    do_cmd(rsa);
    load_op(0, n, NW);
    load_op(1, d, NW);
    load_op(2, m, NW);
    kick_check();
  endtask

  // Now in WAIT cycle 1; raise eng_done during WAIT cycle d.
  task automatic wait_done(input int d, input logic [63:0] r);
    for (int i = 1; i < d; i++) begin
      chk("no_out_valid_wait", out_valid, 0);
      tick();
    end
    eng_done   = 1'b1;
    eng_result = r;
    tick();
    eng_done   = 1'b0;
    eng_result = {$urandom, $urandom};
    for (int i = 0; i < NW; i++) exp_q.push_back(r[i*32 +: 32]);
    chk("out_valid_after_done", out_valid, 1);
  endtask

  // Drain exp_q; hold<0 means a random stall before each word.
  task automatic unload(input int hold);
    int n = exp_q.size();
    for (int k = 0; k < n; k++) begin
      logic [31:0] w = exp_q.pop_front();
      int h = (hold < 0) ? int'($urandom_range(0, 3)) : hold;
      out_ready = 1'b0;
      for (int s = 0; s < h; s++) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, w);
        tick();
      end
      out_ready = 1'b1;
      chk("out_valid", out_valid, 1);
      chk("out_data", out_data, w);
      chk("out_last", out_last, (exp_q.size() == 0));
      chk("eng_is_rsa_unload", eng_is_rsa, mdl_rsa);
      tick();
      out_ready = 1'b0;
    end
    chk("out_valid_drained", out_valid, 0);
    chk("busy_drained", busy, 0);
    chk("cmd_ready_drained", cmd_ready, 1);
  endtask

  initial begin
    int sc;
    cmd_valid = 0; cmd_is_rsa = 0; abort = 0; err_clr = 0; in_valid = 0; in_data = '0;
    out_ready = 0; eng_done = 0; eng_error = 0; eng_result = '0;
    mdl_n = '0; mdl_d = '0; mdl_m = '0; mdl_rsa = 0;
    rstn = 1'b0;
    repeat (3) tick();
    rstn = 1'b1;
    tick();

    // Reset state.
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_state", dbg_state, ST_IDLE);
    chk("rst_err_code", err_code, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_eng_n", eng_n, 0);
    chk("rst_eng_start", eng_start, 0);

    // Packing and single start pulse, then unload with a 3-cycle stall.
    full_load(1'b1, 64'hBBBB0001_AAAA0000, 64'hDDDD0003_CCCC0002, 64'hFFFF0005_EEEE0004);
    chk("pack_n_literal", eng_n, 64'hBBBB0001_AAAA0000);
    wait_done(5, 64'hDEADBEEF_01234567);
    chk("first_word_literal", out_data, 32'h01234567);
    unload(3);

    // Timeout: err rises right after the 16th WAIT cycle.
    full_load(1'b0, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
    for (int i = 1; i <= TIMEOUT_CYC; i++) begin
      chk("no_err_in_wait", err, 0);
      tick();
    end
    chk("tmo_err", err, 1);
    chk("tmo_code", err_code, 2'b01);
    chk("tmo_busy", busy, 1);
    chk("tmo_in_ready", in_ready, 0);
    eng_done = 1'b1;                // ignored outside WAIT
    tick();
    eng_done = 1'b0;
    chk("err_ignores_done", out_valid, 0);
    chk("err_held", err_code, 2'b01);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_err", err, 0);
    chk("clr_code", err_code, 0);
    chk("clr_cmd_ready", cmd_ready, 1);

    // Engine error and done together: error wins; abort clears it.
    full_load(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
    tick(); tick();
    eng_done = 1'b1; eng_error = 1'b1;
    tick();
    eng_done = 1'b0; eng_error = 1'b0;
    chk("eng_err_code", err_code, 2'b10);
    chk("eng_err_flag", err, 1);
    for (int i = 0; i < 3; i++) begin
      chk("eng_err_no_out", out_valid, 0);
      tick();
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_err_code", err_code, 0);
    chk("abort_err_idle", cmd_ready, 1);

    // Abort after one D word: no start, operands retained, next command works.
    do_cmd(1'b0);
    load_op(0, {$urandom, $urandom}, NW);
    load_op(1, {$urandom, $urandom}, 1);
    sc = start_cnt;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_cmd_ready", cmd_ready, 1);
    chk("abort_busy", busy, 0);
    for (int i = 0; i < 4; i++) tick();
    chk("abort_no_start", start_cnt, sc);
    chk("abort_keep_n", eng_n, mdl_n);
    chk("abort_keep_d", eng_d, mdl_d);
    full_load(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
    wait_done(TIMEOUT_CYC, {$urandom, $urandom});   // done on the last WAIT cycle wins
    unload(-1);

    // Reset mid-WAIT, then a stale eng_done.
    full_load(1'b0, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
    tick(); tick();
    rstn = 1'b0;
    #1;
    mdl_n = '0; mdl_d = '0; mdl_m = '0; mdl_rsa = 0;
    chk("rst2_cmd_ready", cmd_ready, 1);
    chk("rst2_busy", busy, 0);
    chk("rst2_eng_n", eng_n, 0);
    chk("rst2_eng_m", eng_m, 0);
    chk("rst2_is_rsa", eng_is_rsa, 0);
    chk("rst2_out_valid", out_valid, 0);
    chk("rst2_out_data", out_data, 0);
    chk("rst2_start", eng_start, 0);
    tick(); tick();
    rstn = 1'b1;
    tick();
    eng_done = 1'b1;
    eng_result = {$urandom, $urandom};
    tick();
    eng_done = 1'b0;
    chk("stale_done_no_out", out_valid, 0);
    chk("stale_done_idle", busy, 0);

    // Randomized transactions.
    for (int t = 0; t < 20; t++) begin
      full_load(1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom},
                {$urandom, $urandom});
      wait_done(int'($urandom_range(1, TIMEOUT_CYC)), {$urandom, $urandom});
      unload(-1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
